// File: rtl/prefix_adder_bist.sv
// prefix_adder_bist
// Built-in self-test driver and checker for a WIDTH-bit prefix adder.
// Two LFSRs generate operands A and B, which are registered onto op_a/op_b
// and sent to the adder under test. The adder's result comes back on
// dut_sum and is compared against a behavioural A+B. That expected value
// is delayed through a pipeline that matches the adder's latency.
// Mismatches are counted, and the first failing vector is captured.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous active-high reset
//   start        in   1        run request; honoured only in IDLE or DONE
//   num_vec      in   CNT_W    vectors to run, latched with start
//   op_a, op_b   out  WIDTH    registered operands to the adder under test
//   dut_sum      in   WIDTH+1  adder result
//   busy         out  1        run in progress (RUN or DRAIN)
//   done         out  1        run finished; held until next start or rst
//   err_count    out  CNT_W    saturating mismatch count
//   first_err_v  out  1        first-failure record valid
//   first_err_a  out  WIDTH    op_a of the first failing vector
//   first_err_b  out  WIDTH    op_b of the first failing vector
//   first_err_s  out  WIDTH+1  dut_sum seen for the first failing vector
module prefix_adder_bist #(
  parameter int               WIDTH   = 32,
  parameter int               DUT_LAT = 0,
  parameter int               CNT_W   = 20,
  parameter logic [WIDTH-1:0] SEED_A  = WIDTH'(32'h0000_0001),
  parameter logic [WIDTH-1:0] SEED_B  = WIDTH'(32'h0000_ACE1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   dut_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_v,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_s
);

  localparam logic [WIDTH-1:0] TAPS       = WIDTH'(32'h8020_0003);
  // An all-zero seed would lock the LFSR at zero, so substitute 1.
  localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
  localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? WIDTH'(1) : SEED_B;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One entry of the expected-value pipeline.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
  } exp_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr_a;
  logic [WIDTH-1:0] lfsr_b;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] check_cnt;
  exp_t             pipe [0:DUT_LAT];

  logic [WIDTH:0]   next_sum;
  logic             check_now;
  logic             mismatch;
  logic             last_issue;
  logic             last_check;

  // Galois right-shift LFSR step.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return {1'b0, x[WIDTH-1:1]} ^ (x[0] ? TAPS : '0);
  endfunction

  // The last pipeline stage lines up with the dut_sum of the vector it
  // describes. The compare uses !== so that X/Z coming back from the
  // adder is counted as a failure.
  always_comb begin
    next_sum   = {1'b0, lfsr_a} + {1'b0, lfsr_b};
    check_now  = pipe[DUT_LAT].valid;
    mismatch   = check_now && (dut_sum !== pipe[DUT_LAT].s);
    last_issue = (issue_cnt == num_vec_q - CNT_W'(1));
    last_check = check_now && (check_cnt == num_vec_q - CNT_W'(1));
  end

  // Controller, operand issue, expected pipeline and result capture.
  // Checking runs independently of state, so a check that is still in
  // flight retires correctly in DRAIN. An accepted start overrides
  // everything because no checks are pending in IDLE or DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr_a      <= SEED_A_EFF;
      lfsr_b      <= SEED_B_EFF;
      op_a        <= '0;
      op_b        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      num_vec_q   <= '0;
      issue_cnt   <= '0;
      check_cnt   <= '0;
      err_count   <= '0;
      first_err_v <= 1'b0;
      first_err_a <= '0;
      first_err_b <= '0;
      first_err_s <= '0;
      for (int i = 0; i <= DUT_LAT; i++) pipe[i] <= '0;
    end else begin
      for (int i = 1; i <= DUT_LAT; i++) pipe[i] <= pipe[i-1];
      pipe[0].valid <= 1'b0;

      if (check_now) begin
        check_cnt <= check_cnt + CNT_W'(1);
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          if (!first_err_v) begin
            first_err_v <= 1'b1;
            first_err_a <= pipe[DUT_LAT].a;
            first_err_b <= pipe[DUT_LAT].b;
            first_err_s <= dut_sum;
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            lfsr_a      <= SEED_A_EFF;
            lfsr_b      <= SEED_B_EFF;
            num_vec_q   <= num_vec;
            issue_cnt   <= '0;
            check_cnt   <= '0;
            err_count   <= '0;
            first_err_v <= 1'b0;
            first_err_a <= '0;
            first_err_b <= '0;
            first_err_s <= '0;
            for (int i = 0; i <= DUT_LAT; i++) pipe[i].valid <= 1'b0;
          end
        end
        RUN: begin
          // With zero vectors requested there is nothing to check.
          if (num_vec_q == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            op_a      <= lfsr_a;
            op_b      <= lfsr_b;
            pipe[0]   <= {1'b1, lfsr_a, lfsr_b, next_sum};
            lfsr_a    <= lfsr_step(lfsr_a);
            lfsr_b    <= lfsr_step(lfsr_b);
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_check) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
